// File: rtl/cl_pkg.sv
// Shared encodings for the 1-bit logic cell and its bit-serial sequencer.
//   op_e    : 2-bit operation codes understood by cl
//   state_t : sequencer FSM states
package cl_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cl.sv
// 1-bit logic cell.
//   a, b : operand bits
//   op   : AND / OR / XOR / NOT a (b ignored for NOT a)
//   y    : combinational result bit
module cl
  import cl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOTA: y = ~a;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/cl_serial_seq.sv
// Bit-serial sequencer wrapping the 1-bit cl cell into a WIDTH-bit logic unit.
// One bit pair (LSB first) is processed per cycle; an operation takes WIDTH
// cycles of RUN followed by a single DONE cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : request; honoured only in IDLE or DONE
//   op, a, b   : operation and operands, captured on an accepted start
//   busy       : high while in RUN
//   done       : one-cycle completion pulse
//   result     : assembled result, stable from done until the next accepted start
//   parity     : XOR of all result bits (only when CL_SERIAL_PARITY_EN is defined)
// Optional feature macro: CL_SERIAL_PARITY_EN
module cl_serial_seq
  import cl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef CL_SERIAL_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             bit_y;
  logic             accept;

  // Start is only honoured when no operation is in flight.
  assign accept = start && (state == IDLE || state == DONE);

  cl u_cl (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .op (op_q),
    .y  (bit_y)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      op_q   <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      op_q <= op;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      // New bit enters at the MSB so bit 0 lands in result[0] after WIDTH shifts.
      result <= {bit_y, result[WIDTH-1:1]};
      // Saturate on the final edge rather than wrapping past WIDTH-1.
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

`ifdef CL_SERIAL_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)              parity <= 1'b0;
    else if (accept)        parity <= 1'b0;
    else if (state == RUN)  parity <= parity ^ bit_y;
  end
`endif

endmodule

// File: tb/tb_cl_serial_seq.sv
module tb_cl_serial_seq;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] result;
`ifdef CL_SERIAL_PARITY_EN
  logic             parity;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cl_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef CL_SERIAL_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then follow the operation until done or timeout.
  // done_cyc is the cycle index of done (cycle 1 = first cycle after start edge),
  // or -1 on timeout; busy_cnt counts RUN cycles seen before done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                        output int done_cyc, output int busy_cnt, output logic [7:0] res);
    a = ta; b = tb_; op = top; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = -1;
    busy_cnt = 0;
    res = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        done_cyc = c;
        res = result;
        break;
      end
      if (busy) busy_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    tick(); tick();
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    reset = 1'b0;
    tick();
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_ops();
    logic [7:0] exp_r [4];
    int dc, bc;
    logic [7:0] r;
    exp_r[0] = 8'hC0; exp_r[1] = 8'hFC; exp_r[2] = 8'h3C; exp_r[3] = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      run_op(8'hF0, 8'hCC, 2'(i), dc, bc, r);
      total++; if (dc != 9) begin bad++; $display("FAIL op%0d_latency got=%0d exp=9", i, dc); end
      total++; if (bc != 8) begin bad++; $display("FAIL op%0d_busy_cycles got=%0d exp=8", i, bc); end
      total++; if (r !== exp_r[i]) begin bad++; $display("FAIL op%0d_result got=%h exp=%h", i, r, exp_r[i]); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL op%0d_done_width got=%b exp=0", i, done); end
      total++; if (result !== exp_r[i]) begin bad++; $display("FAIL op%0d_result_hold got=%h exp=%h", i, result, exp_r[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0, first = -1;
    logic [7:0] r = '0;
    a = 8'hF0; b = 8'hCC; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin
        ndone++;
        if (first < 0) begin first = c; r = result; end
      end
      if (c == 3) begin a = 8'hFF; b = 8'hFF; op = 2'b01; start = 1'b1; end
      if (c == 4) start = 1'b0;
      tick();
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    total++; if (first != 9) begin bad++; $display("FAIL ign_latency got=%0d exp=9", first); end
    total++; if (r !== 8'hC0) begin bad++; $display("FAIL ign_result got=%h exp=c0", r); end
  endtask

  task automatic test_abort();
    int ndone = 0;
    a = 8'hF0; b = 8'hCC; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL abort_result got=%h exp=00", result); end
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      tick();
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", ndone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1;
    logic [7:0] r1 = '0, r2 = '0;
    logic busy_after = 1'b0;
    a = 8'hF0; b = 8'hCC; op = 2'b00; start = 1'b1;
    tick();
    a = 8'hAA; b = 8'h0F; op = 2'b10;
    for (int c = 1; c <= 25; c++) begin
      if (done) begin
        if (d1 < 0) begin d1 = c; r1 = result; end
        else if (d2 < 0) begin d2 = c; r2 = result; end
      end
      if (c == 10) begin busy_after = busy; start = 1'b0; end
      if (d2 >= 0) break;
      tick();
    end
    tick();
    total++; if (d1 != 9)  begin bad++; $display("FAIL b2b_first_latency got=%0d exp=9", d1); end
    total++; if (r1 !== 8'hC0) begin bad++; $display("FAIL b2b_first_result got=%h exp=c0", r1); end
    total++; if (busy_after !== 1'b1) begin bad++; $display("FAIL b2b_rerun got=%b exp=1", busy_after); end
    total++; if (d2 != 18) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=18", d2); end
    total++; if (r2 !== 8'hA5) begin bad++; $display("FAIL b2b_second_result got=%h exp=a5", r2); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

`ifdef CL_SERIAL_PARITY_EN
  task automatic test_parity();
    int dc, bc;
    logic [7:0] r;
    run_op(8'hF1, 8'h00, 2'b11, dc, bc, r);
    total++; if (r !== 8'h0E) begin bad++; $display("FAIL par1_result got=%h exp=0e", r); end
    total++; if (parity !== 1'b1) begin bad++; $display("FAIL par1_parity got=%b exp=1", parity); end
    tick();
    run_op(8'hF0, 8'hCC, 2'b01, dc, bc, r);
    total++; if (r !== 8'hFC) begin bad++; $display("FAIL par2_result got=%h exp=fc", r); end
    total++; if (parity !== 1'b0) begin bad++; $display("FAIL par2_parity got=%b exp=0", parity); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef CL_SERIAL_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
